// File: rtl/img2col_ctrl_pkg.sv
// Shared definitions for the img2col layer controller: field widths, FSM
// state encoding, config/derived payload structs and the legality check.
package img2col_ctrl_pkg;

    // Raw layer configuration widths
    localparam int unsigned TENSOR_W   = 8;
    localparam int unsigned KERNEL_W   = 4;
    localparam int unsigned CHANNELS_W = 8;
    localparam int unsigned STRIDE_W   = 4;
    localparam int unsigned KNUMS_W    = 8;

    // Serial-to-parallel lane count and the width of a remainder modulo it
    localparam int unsigned S2P_SIZE = 4;
    localparam int unsigned REM_W    = 2;

    // Derived config widths, matching the img2col datapath inputs
    localparam int unsigned OFS_W   = 8;
    localparam int unsigned TMS_W   = 12;
    localparam int unsigned WW_W    = 16;
    localparam int unsigned BUF_T_W = 14;
    localparam int unsigned BUF_W_W = 7;
    localparam int unsigned SROW_W  = 8;
    localparam int unsigned SCH_W   = 16;
    localparam int unsigned PERF_W  = 32;

    // Smallest legal values of the zero-checked config fields
    localparam int unsigned MIN_STRIDE   = 1;
    localparam int unsigned MIN_KERNEL   = 1;
    localparam int unsigned MIN_CHANNELS = 1;
    localparam int unsigned MIN_KNUMS    = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_PREP = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef struct packed {
        logic [TENSOR_W-1:0]   tensor;
        logic [KERNEL_W-1:0]   kernel;
        logic [CHANNELS_W-1:0] channels;
        logic [STRIDE_W-1:0]   stride;
        logic [KNUMS_W-1:0]    knums;
    } layer_cfg_t;

    typedef struct packed {
        logic [KERNEL_W-1:0] kernel;
        logic [STRIDE_W-1:0] stride;
        logic [TMS_W-1:0]    t_mul_s;
        logic [OFS_W-1:0]    ofs;
        logic [REM_W-1:0]    t_len_rem;
        logic [BUF_T_W-1:0]  buf_t;
        logic [SROW_W-1:0]   srow;
        logic [SCH_W-1:0]    sch;
        logic [BUF_W_W-1:0]  buf_w;
        logic [WW_W-1:0]     w_width;
        logic [REM_W-1:0]    kn_rem;
        logic [REM_W-1:0]    w_rem;
    } derived_t;

    // A config is runnable when no divisor/size is zero and the kernel fits
    function automatic logic cfg_legal(input layer_cfg_t c);
        return (c.stride   >= STRIDE_W'(MIN_STRIDE))
            && (c.kernel   >= KERNEL_W'(MIN_KERNEL))
            && (TENSOR_W'(c.kernel) <= c.tensor)
            && (c.channels >= CHANNELS_W'(MIN_CHANNELS))
            && (c.knums    >= KNUMS_W'(MIN_KNUMS));
    endfunction

endpackage

// File: rtl/img2col_ctrl_div.sv
// Iterative subtract divider: one subtraction per cycle after start_i.
// Ports: start_i loads dividend/divisor; abort_i cancels; quotient_o holds
// the result; valid_c is high (combinationally) in the cycle the remainder
// drops below the divisor, after which the unit idles holding quotient_o.
// A zero divisor never completes; the caller must not start with one.
module img2col_ctrl_div
    import img2col_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [TENSOR_W-1:0] dividend_i,
    input  logic [STRIDE_W-1:0] divisor_i,
    output logic [TENSOR_W-1:0] quotient_o,
    output logic                valid_c
);

    logic [TENSOR_W-1:0] rem_q, rem_d;
    logic [TENSOR_W-1:0] div_q, div_d;
    logic [TENSOR_W-1:0] quot_q, quot_d;
    logic                run_q, run_d;

    assign valid_c    = run_q && (rem_q < div_q);
    assign quotient_o = quot_q;

    // Next-state: load, subtract-and-count, or stop
    always_comb begin
        rem_d  = rem_q;
        div_d  = div_q;
        quot_d = quot_q;
        run_d  = run_q;
        if (abort_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            rem_d  = dividend_i;
            div_d  = TENSOR_W'(divisor_i);
            quot_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (valid_c) begin
                run_d = 1'b0;
            end else begin
                rem_d  = rem_q - div_q;
                quot_d = quot_q + TENSOR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            div_q  <= '0;
            quot_q <= '0;
            run_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            div_q  <= div_d;
            quot_q <= quot_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/img2col_ctrl.sv
// img2col layer controller: validates a layer config, derives the img2col
// addressing parameters, enables the datapath and waits for both of its
// completion pulses.
// Inputs : clk, rst (async, active-high), start, abort, raw layer config
//          (tensor_size, kernel_size, channels, stride, kernel_nums),
//          tensor_done / weight_done from the datapath.
// Outputs: enable (RUN only), registered derived config, busy, done and
//          cfg_err pulses.
// Build option: IMG2COL_CTRL_PERF_EN adds perf_cycles, the saturating RUN
//          cycle count of the last job.
module img2col_ctrl
    import img2col_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TENSOR_W-1:0]   tensor_size,
    input  logic [KERNEL_W-1:0]   kernel_size,
    input  logic [CHANNELS_W-1:0] channels,
    input  logic [STRIDE_W-1:0]   stride,
    input  logic [KNUMS_W-1:0]    kernel_nums,
    input  logic                  tensor_done,
    input  logic                  weight_done,
    output logic                  enable,
    output logic [KERNEL_W-1:0]   kernel_size_o,
    output logic [STRIDE_W-1:0]   stride_o,
    output logic [TMS_W-1:0]      t_mul_s,
    output logic [OFS_W-1:0]      out_feature_size,
    output logic [REM_W-1:0]      img2col_t_length_rem,
    output logic [BUF_T_W-1:0]    buffer_row_nums_t,
    output logic [SROW_W-1:0]     switch_row_add_nums,
    output logic [SCH_W-1:0]      switch_channel_add_nums,
    output logic [BUF_T_W-1:0]    buffer_col_nums,
    output logic [BUF_W_W-1:0]    buffer_row_nums_w,
    output logic [WW_W-1:0]       img2col_w_width,
    output logic [REM_W-1:0]      kernel_nums_rem,
    output logic [REM_W-1:0]      img2col_w_width_rem,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
`ifdef IMG2COL_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_cycles
`endif
);

    localparam int unsigned WWF_W = 2 * KERNEL_W + CHANNELS_W;

    state_e     state_q, state_d;
    layer_cfg_t cfg_q, cfg_d, cfg_in;
    derived_t   der_q, der_d, der_calc;
    logic       tflag_q, tflag_d, wflag_q, wflag_d;
    logic       busy_q, busy_d, enable_q, enable_d;
    logic       done_q, done_d, cfg_err_q, cfg_err_d;
    logic       legal_in, accept;
    logic [TENSOR_W-1:0] quot;
    logic                div_valid_c;

    assign cfg_in   = '{tensor: tensor_size, kernel: kernel_size, channels: channels,
                        stride: stride, knums: kernel_nums};
    assign legal_in = cfg_legal(cfg_in);
    assign accept   = (state_q == ST_IDLE) && start && legal_in;

    // (tensor - kernel) / stride, started from the raw inputs on acceptance
    img2col_ctrl_div u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (accept),
        .abort_i    (abort && (state_q == ST_CALC)),
        .dividend_i (tensor_size - TENSOR_W'(kernel_size)),
        .divisor_i  (stride),
        .quotient_o (quot),
        .valid_c    (div_valid_c)
    );

    // Derived parameters: full-width products, truncated on assignment
    logic [TENSOR_W:0]                ofs_full;
    logic [TENSOR_W+STRIDE_W-1:0]     tms_full;
    logic [2*KERNEL_W-1:0]            ksq_full;
    logic [WWF_W-1:0]                 ww_full;
    logic [WWF_W:0]                   ww_ceil;
    logic [KNUMS_W:0]                 kn_ceil;
    logic [2*OFS_W-1:0]               ofs_sq;
    logic [TENSOR_W-1:0]              srow_full;
    logic [2*TENSOR_W-1:0]            sch_full;

    always_comb begin
        ofs_full  = (TENSOR_W+1)'(quot) + (TENSOR_W+1)'(1);
        tms_full  = (TENSOR_W+STRIDE_W)'(cfg_q.tensor) * (TENSOR_W+STRIDE_W)'(cfg_q.stride);
        ksq_full  = (2*KERNEL_W)'(cfg_q.kernel) * (2*KERNEL_W)'(cfg_q.kernel);
        ww_full   = WWF_W'(ksq_full) * WWF_W'(cfg_q.channels);
        ww_ceil   = (WWF_W+1)'(ww_full) + (WWF_W+1)'(S2P_SIZE - 1);
        kn_ceil   = (KNUMS_W+1)'(cfg_q.knums) + (KNUMS_W+1)'(S2P_SIZE - 1);
        srow_full = cfg_q.tensor - TENSOR_W'(cfg_q.kernel);
        sch_full  = (2*TENSOR_W)'(cfg_q.tensor) * (2*TENSOR_W)'(srow_full);

        der_calc.kernel  = cfg_q.kernel;
        der_calc.stride  = cfg_q.stride;
        der_calc.ofs     = OFS_W'(ofs_full);
        der_calc.t_mul_s = TMS_W'(tms_full);
        der_calc.w_width = WW_W'(ww_full);
        der_calc.buf_t   = BUF_T_W'(ww_ceil / (WWF_W+1)'(S2P_SIZE));
        der_calc.w_rem   = REM_W'(ww_full % WWF_W'(S2P_SIZE));
        der_calc.buf_w   = BUF_W_W'(kn_ceil / (KNUMS_W+1)'(S2P_SIZE));
        der_calc.kn_rem  = REM_W'(cfg_q.knums % KNUMS_W'(S2P_SIZE));
        ofs_sq           = (2*OFS_W)'(der_calc.ofs) * (2*OFS_W)'(der_calc.ofs);
        der_calc.t_len_rem = REM_W'(ofs_sq % (2*OFS_W)'(S2P_SIZE));
        der_calc.srow    = SROW_W'(srow_full);
        der_calc.sch     = SCH_W'(sch_full);
    end

    // FSM next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        der_d     = der_q;
        tflag_d   = 1'b0;
        wflag_d   = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_d = cfg_in;
                    if (legal_in) state_d = ST_CALC;
                    else          cfg_err_d = 1'b1;
                end
            end
            ST_CALC: begin
                if (abort)            state_d = ST_IDLE;
                else if (div_valid_c) state_d = ST_PREP;
            end
            ST_PREP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                    der_d   = der_calc;
                end
            end
            ST_RUN: begin
                // Flags are registered, so DONE follows one cycle after both are set
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tflag_q && wflag_q) begin
                    state_d = ST_DONE;
                end else begin
                    tflag_d = tflag_q | tensor_done;
                    wflag_d = wflag_q | weight_done;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d   = (state_d != ST_IDLE);
        enable_d = (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            der_q     <= '0;
            tflag_q   <= 1'b0;
            wflag_q   <= 1'b0;
            busy_q    <= 1'b0;
            enable_q  <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            der_q     <= der_d;
            tflag_q   <= tflag_d;
            wflag_q   <= wflag_d;
            busy_q    <= busy_d;
            enable_q  <= enable_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef IMG2COL_CTRL_PERF_EN
    // RUN-cycle counter, cleared on an accepted start, saturating
    logic [PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept)
            perf_d = '0;
        else if ((state_q == ST_RUN) && (perf_q != {PERF_W{1'b1}}))
            perf_d = perf_q + PERF_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

    assign enable                  = enable_q;
    assign busy                    = busy_q;
    assign done                    = done_q;
    assign cfg_err                 = cfg_err_q;
    assign kernel_size_o           = der_q.kernel;
    assign stride_o                = der_q.stride;
    assign t_mul_s                 = der_q.t_mul_s;
    assign out_feature_size        = der_q.ofs;
    assign img2col_t_length_rem    = der_q.t_len_rem;
    assign buffer_row_nums_t       = der_q.buf_t;
    assign buffer_col_nums         = der_q.buf_t;
    assign switch_row_add_nums     = der_q.srow;
    assign switch_channel_add_nums = der_q.sch;
    assign buffer_row_nums_w       = der_q.buf_w;
    assign img2col_w_width         = der_q.w_width;
    assign kernel_nums_rem         = der_q.kn_rem;
    assign img2col_w_width_rem     = der_q.w_rem;

endmodule

// File: tb/tb_img2col_ctrl.sv
// Self-checking bench for img2col_ctrl: fixed vector table, hand-written
// corner sequences and randomized jobs against an arithmetic reference model.
module tb_img2col_ctrl;
    import img2col_ctrl_pkg::*;

    localparam int S2P = int'(S2P_SIZE);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, tensor_done = 1'b0, weight_done = 1'b0;
    logic [TENSOR_W-1:0]   tensor_size = '0;
    logic [KERNEL_W-1:0]   kernel_size = '0;
    logic [CHANNELS_W-1:0] channels = '0;
    logic [STRIDE_W-1:0]   stride = '0;
    logic [KNUMS_W-1:0]    kernel_nums = '0;
    logic                  enable, busy, done, cfg_err;
    logic [KERNEL_W-1:0]   kernel_size_o;
    logic [STRIDE_W-1:0]   stride_o;
    logic [TMS_W-1:0]      t_mul_s;
    logic [OFS_W-1:0]      out_feature_size;
    logic [REM_W-1:0]      img2col_t_length_rem, kernel_nums_rem, img2col_w_width_rem;
    logic [BUF_T_W-1:0]    buffer_row_nums_t, buffer_col_nums;
    logic [SROW_W-1:0]     switch_row_add_nums;
    logic [SCH_W-1:0]      switch_channel_add_nums;
    logic [BUF_W_W-1:0]    buffer_row_nums_w;
    logic [WW_W-1:0]       img2col_w_width;
`ifdef IMG2COL_CTRL_PERF_EN
    logic [PERF_W-1:0]     perf_cycles;
`endif

    always #5 clk = ~clk;

    img2col_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels),
        .stride(stride), .kernel_nums(kernel_nums),
        .tensor_done(tensor_done), .weight_done(weight_done),
        .enable(enable), .kernel_size_o(kernel_size_o), .stride_o(stride_o),
        .t_mul_s(t_mul_s), .out_feature_size(out_feature_size),
        .img2col_t_length_rem(img2col_t_length_rem), .buffer_row_nums_t(buffer_row_nums_t),
        .switch_row_add_nums(switch_row_add_nums), .switch_channel_add_nums(switch_channel_add_nums),
        .buffer_col_nums(buffer_col_nums), .buffer_row_nums_w(buffer_row_nums_w),
        .img2col_w_width(img2col_w_width), .kernel_nums_rem(kernel_nums_rem),
        .img2col_w_width_rem(img2col_w_width_rem),
        .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef IMG2COL_CTRL_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    typedef struct {
        int ofs, tms, ww, bcol, wrem, brw, knrem, tlrem, srow, sch;
    } der_t;

    typedef struct {
        int   t, k, c, s, n, ta, wa;
        bit   err;
        int   calc;
        der_t e;
    } vec_t;

    int n_chk = 0, n_pass = 0;
    int last_ofs = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model straight from the layer arithmetic
    function automatic der_t model(input int t, input int k, input int c, input int n, input int s);
        der_t d;
        int   q, ww;
        q       = (t - k) / s;
        ww      = k * k * c;
        d.ofs   = (q + 1) % (1 << OFS_W);
        d.tms   = (t * s) % (1 << TMS_W);
        d.ww    = ww % (1 << WW_W);
        d.bcol  = ((ww + S2P - 1) / S2P) % (1 << BUF_T_W);
        d.wrem  = ww % S2P;
        d.brw   = ((n + S2P - 1) / S2P) % (1 << BUF_W_W);
        d.knrem = n % S2P;
        d.tlrem = (d.ofs * d.ofs) % S2P;
        d.srow  = (t - k) % (1 << SROW_W);
        d.sch   = (t * (t - k)) % (1 << SCH_W);
        return d;
    endfunction

    task automatic check_der(input string nm, input der_t e, input int k, input int s);
        check({nm, "_ofs"},   int'(out_feature_size), e.ofs);
        check({nm, "_tms"},   int'(t_mul_s), e.tms);
        check({nm, "_ww"},    int'(img2col_w_width), e.ww);
        check({nm, "_bcol"},  int'(buffer_col_nums), e.bcol);
        check({nm, "_brt"},   int'(buffer_row_nums_t), e.bcol);
        check({nm, "_wrem"},  int'(img2col_w_width_rem), e.wrem);
        check({nm, "_brw"},   int'(buffer_row_nums_w), e.brw);
        check({nm, "_knrem"}, int'(kernel_nums_rem), e.knrem);
        check({nm, "_tlrem"}, int'(img2col_t_length_rem), e.tlrem);
        check({nm, "_srow"},  int'(switch_row_add_nums), e.srow);
        check({nm, "_sch"},   int'(switch_channel_add_nums), e.sch);
        check({nm, "_kso"},   int'(kernel_size_o), k);
        check({nm, "_so"},    int'(stride_o), s);
    endtask

    task automatic set_cfg(input int t, input int k, input int c, input int s, input int n);
        tensor_size = TENSOR_W'(t);
        kernel_size = KERNEL_W'(k);
        channels    = CHANNELS_W'(c);
        stride      = STRIDE_W'(s);
        kernel_nums = KNUMS_W'(n);
    endtask

    // Pulse start, scramble the raw inputs, wait (bounded) for enable
    task automatic launch(input int t, input int k, input int c, input int s, input int n,
                          output int lat);
        set_cfg(t, k, c, s, n);
        start = 1'b1;
        tick;
        start = 1'b0;
        set_cfg(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        lat = 1;
        while (!enable && lat < 600) begin
            tick;
            lat++;
        end
    endtask

    task automatic watch(input int n, output int nd, output int ne);
        nd = 0;
        ne = 0;
        repeat (n) begin
            tick;
            nd += int'(done);
            ne += int'(enable);
        end
    endtask

    task automatic run_job(input int t, input int k, input int c, input int s, input int n,
                           input int ta, input int wa, input int calc, input der_t e,
                           input string nm);
        int lat, cyc, lastp;
        bit seen, en_drop;
        launch(t, k, c, s, n, lat);
        check({nm, "_latency"}, lat, calc + 2);
        check_der(nm, e, k, s);
        cyc = 0; seen = 1'b0; en_drop = 1'b0;
        lastp = (ta > wa) ? ta : wa;
        while (!seen && cyc < lastp + 10) begin
            tensor_done = (cyc == ta);
            weight_done = (cyc == wa);
            tick;
            cyc++;
            if (done) seen = 1'b1;
            else if (!enable) en_drop = 1'b1;
        end
        tensor_done = 1'b0;
        weight_done = 1'b0;
        check({nm, "_done_cycle"}, seen ? cyc : -1, lastp + 2);
        check({nm, "_en_drop"}, int'(en_drop), 0);
        check({nm, "_en_in_done"}, int'(enable), 0);
`ifdef IMG2COL_CTRL_PERF_EN
        check({nm, "_perf"}, int'(perf_cycles), lastp + 2);
`endif
        tick;
        check({nm, "_done_width"}, int'(done), 0);
        check({nm, "_idle_busy"}, int'(busy), 0);
        check({nm, "_hold_ofs"}, int'(out_feature_size), e.ofs);
        check({nm, "_hold_sch"}, int'(switch_channel_add_nums), e.sch);
        last_ofs = e.ofs;
    endtask

    task automatic run_err(input int t, input int k, input int c, input int s, input int n,
                           input string nm);
        set_cfg(t, k, c, s, n);
        start = 1'b1;
        tick;
        start = 1'b0;
        check({nm, "_cfg_err"}, int'(cfg_err), 1);
        check({nm, "_busy"}, int'(busy), 0);
        check({nm, "_enable"}, int'(enable), 0);
        tick;
        check({nm, "_cfg_err_width"}, int'(cfg_err), 0);
        check({nm, "_busy2"}, int'(busy) + int'(enable), 0);
        check({nm, "_keeps_cfg"}, int'(out_feature_size), last_ofs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        int   lat, nd, ne;

        vt[0] = '{8, 3, 2, 1, 5, 4, 9, 1'b0, 6, '{6, 8, 18, 5, 2, 2, 1, 0, 5, 40}};
        vt[1] = '{7, 3, 1, 2, 4, 3, 3, 1'b0, 3, '{3, 14, 9, 3, 1, 1, 0, 1, 4, 28}};
        vt[2] = '{5, 5, 3, 1, 1, 0, 2, 1'b0, 1, '{1, 5, 75, 19, 3, 1, 1, 1, 0, 0}};
        vt[3] = '{10, 2, 4, 3, 8, 5, 1, 1'b0, 3, '{3, 30, 16, 4, 0, 2, 0, 1, 8, 80}};
        vt[4] = '{8, 3, 2, 0, 5, 0, 0, 1'b1, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[5] = '{8, 9, 2, 1, 5, 0, 0, 1'b1, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[6] = '{8, 3, 0, 1, 5, 0, 0, 1'b1, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[7] = '{8, 3, 2, 1, 0, 0, 0, 1'b1, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[8] = '{6, 0, 2, 1, 1, 0, 0, 1'b1, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

        // Reset state
        tick; tick;
        check("rst_busy", int'(busy), 0);
        check("rst_enable", int'(enable), 0);
        check("rst_done", int'(done) + int'(cfg_err), 0);
        check("rst_ofs", int'(out_feature_size), 0);
        check("rst_ww", int'(img2col_w_width), 0);
        rst = 1'b0;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("idle_abort_ignored", int'(busy), 0);

        foreach (vt[i]) begin
            if (vt[i].err)
                run_err(vt[i].t, vt[i].k, vt[i].c, vt[i].s, vt[i].n, $sformatf("vec%0d", i));
            else
                run_job(vt[i].t, vt[i].k, vt[i].c, vt[i].s, vt[i].n, vt[i].ta, vt[i].wa,
                        vt[i].calc, vt[i].e, $sformatf("vec%0d", i));
        end

        // Completion pulses in CALC ignored; start during RUN ignored
        set_cfg(8, 3, 2, 1, 5);
        start = 1'b1;
        tick;
        start = 1'b0;
        tensor_done = 1'b1;
        weight_done = 1'b1;
        tick;
        tensor_done = 1'b0;
        weight_done = 1'b0;
        lat = 2;
        while (!enable && lat < 600) begin tick; lat++; end
        check("calc_pulse_latency", lat, 8);
        weight_done = 1'b1;
        tick;
        weight_done = 1'b0;
        set_cfg(20, 1, 1, 1, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        watch(5, nd, ne);
        check("calc_pulse_no_done", nd, 0);
        check("calc_pulse_enable", ne, 5);
        check("busy_start_ignored", int'(out_feature_size), 6);
        tensor_done = 1'b1;
        tick;
        tensor_done = 1'b0;
        check("late_tdone_not_yet", int'(done), 0);
        tick;
        check("late_tdone_done", int'(done), 1);
        tick;
        check("late_tdone_idle", int'(busy), 0);

        // Abort in the same cycle as the last completion pulse
        launch(7, 3, 1, 2, 4, lat);
        check("abort_job_latency", lat, 5);
        tensor_done = 1'b1;
        tick;
        tensor_done = 1'b0;
        tick; tick;
        weight_done = 1'b1;
        abort = 1'b1;
        tick;
        weight_done = 1'b0;
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_enable", int'(enable), 0);
        watch(4, nd, ne);
        check("abort_no_done", nd + int'(done), 0);

        // Abort during CALC, then start with abort in IDLE (abort ignored)
        set_cfg(200, 1, 1, 1, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("calc_abort_busy", int'(busy), 0);
        watch(3, nd, ne);
        check("calc_abort_quiet", nd + ne + int'(busy), 0);
        set_cfg(9, 2, 1, 1, 1);
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_start_busy", int'(busy), 1);
        lat = 1;
        while (!enable && lat < 600) begin tick; lat++; end
        check("idle_abort_start_latency", lat, 10);

        // Asynchronous reset mid-RUN
        #2 rst = 1'b1;
        #1;
        check("arst_enable", int'(enable), 0);
        check("arst_busy", int'(busy) + int'(done) + int'(cfg_err), 0);
        check("arst_derived", int'(out_feature_size) + int'(switch_channel_add_nums), 0);
        tick;
        rst = 1'b0;
        tensor_done = 1'b1;
        weight_done = 1'b1;
        tick;
        tensor_done = 1'b0;
        weight_done = 1'b0;
        watch(6, nd, ne);
        check("arst_no_done", nd + ne + int'(busy), 0);
        last_ofs = 0;

        // Randomized legal jobs against the reference model
        for (int i = 0; i < 40; i++) begin
            int t, k, c, s, n, ta, wa;
            t  = int'($urandom_range(1, 255));
            k  = int'($urandom_range(1, (t < 15) ? t : 15));
            c  = int'($urandom_range(1, 255));
            s  = int'($urandom_range(1, 15));
            n  = int'($urandom_range(1, 255));
            ta = int'($urandom_range(0, 7));
            wa = int'($urandom_range(0, 7));
            run_job(t, k, c, s, n, ta, wa, (t - k) / s + 1, model(t, k, c, n, s),
                    $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/img2col_ctrl.md
IMG2COL_CTRL -- requirements
Module: img2col_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle request to run one convolution layer; honoured only in IDLE.
REQ-004 abort  input  1  cancels a job in CALC/PREP/RUN.
REQ-005 tensor_size, kernel_size, channels, stride, kernel_nums  input  `TENSOR_SIZE/`KERNEL_SIZE/`CHANNELS_SIZE/`STRIDE_SIZE/`KERNEL_NUMS_SIZE  raw layer config, sampled on accepted start.
REQ-006 tensor_done, weight_done  input  1  completion pulses from the img2col datapath.
REQ-007 enable  output  1  run enable to img2col; high throughout RUN only.
REQ-008 kernel_size_o, stride_o, t_mul_s, out_feature_size, img2col_t_length_rem, buffer_row_nums_t, switch_row_add_nums, switch_channel_add_nums, buffer_col_nums, buffer_row_nums_w, img2col_w_width, kernel_nums_rem, img2col_w_width_rem  output  widths identical to img2col's matching inputs  registered derived config.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse on job completion.
REQ-011 cfg_err  output  1  one-cycle pulse on rejected config.

Function
REQ-012 FSM states IDLE, CALC, PREP, RUN, DONE; encoding free.
REQ-013 IDLE: start=1 latches raw config; illegal config (stride==0, kernel_size==0, kernel_size>tensor_size, channels==0, kernel_nums==0) -> cfg_err pulse next cycle, stay IDLE, enable never asserted.
REQ-014 CALC: q=(tensor_size-kernel_size)/stride by repeated subtraction, one subtract per cycle; exits to PREP the cycle remainder<stride; max tensor_size+1 cycles.
REQ-015 PREP (exactly 1 cycle) registers: out_feature_size=q+1; t_mul_s=tensor_size*stride; img2col_w_width=kernel_size^2*channels; buffer_col_nums=buffer_row_nums_t=ceil(img2col_w_width/`S2P_SIZE); buffer_row_nums_w=ceil(kernel_nums/`S2P_SIZE); img2col_w_width_rem=img2col_w_width mod `S2P_SIZE; kernel_nums_rem=kernel_nums mod `S2P_SIZE; img2col_t_length_rem=out_feature_size^2 mod `S2P_SIZE; switch_row_add_nums=tensor_size-kernel_size; switch_channel_add_nums=tensor_size*(tensor_size-kernel_size).
REQ-016 All products computed at full width, then truncated to output width; truncation is not an error.
REQ-017 Derived outputs stable from first RUN cycle until next accepted start.
REQ-018 RUN: enable=1 from first RUN cycle; tensor_done and weight_done latched into sticky flags; arrival in either order or same cycle accepted.
REQ-019 Both flags set -> DONE next cycle; enable low from DONE onward.
REQ-020 DONE: done=1 for exactly one cycle, flags cleared, return to IDLE.
REQ-021 Completion pulses outside RUN ignored.
REQ-022 abort=1 in CALC/PREP/RUN -> IDLE next cycle, enable=0, no done; abort wins over same-cycle completion; abort in IDLE/DONE ignored.
REQ-023 start while busy ignored.

Reset
REQ-024 rst=1 asynchronously forces IDLE; enable, busy, done, cfg_err, flags and all derived outputs = 0.
REQ-025 Reset mid-job discards job; no done after release.

Configuration
REQ-026 Macro IMG2COL_CTRL_PERF_EN: when defined, output perf_cycles (32 bits) counts RUN cycles of last job, cleared on accepted start, saturates at all-ones, reset 0; when undefined, port and counter absent, other behaviour identical.

Structure
REQ-027 FSM state typedef/localparams and legality-check constants live in the shared `define.v include; S2P, widths from existing macros.
REQ-028 One sub-module img2col_ctrl_div (iterative subtract divider, start/valid handshake) is natural; rest inline.

Verification
REQ-029 tensor 8, kernel 3, ch 2, stride 1, knum 5, S2P 4: out_feature_size=6, t_mul_s=8, img2col_w_width=18, buffer_col_nums=5, rem=2, buffer_row_nums_w=2, kernel_nums_rem=1, t_length_rem=0, switch_row=5, switch_channel=40.
REQ-030 tensor 7, kernel 3, stride 2: CALC 3 cycles, out_feature_size=3; enable rises first RUN cycle.
REQ-031 tensor_done at RUN+4, weight_done at RUN+9 -> done at RUN+11; repeat with both same cycle -> done 2 cycles after.
REQ-032 stride 0 or kernel 9 > tensor 8 -> cfg_err single pulse, busy stays 0, enable never high.
REQ-033 abort same cycle as last done pulse -> IDLE, no done; rst mid-RUN -> all outputs 0 immediately.
REQ-034 PERF_EN build: 20 RUN cycles -> perf_cycles=20; undefined build compiles without port.
